// File: rtl/fechadura_pkg.sv
// fechadura_pkg: shared definitions for the digit-code lock.
//   - FSM state encodings (legacy-compatible 2-bit constants)
//   - active-low seven-segment patterns, bit6=A .. bit0=G
//   - digit_to_seg(): decimal digit to segment pattern
package fechadura_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_ENTRADA   = 2'd0;
    localparam state_t ST_ABERTO    = 2'd1;
    localparam state_t ST_PROGRAMA  = 2'd2;
    localparam state_t ST_BLOQUEADO = 2'd3;

    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Only the low nibble is looked at; callers handle values above 9.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/decod_7seg.sv
// decod_7seg: combinational digit decoder for an active-low 7-segment display.
//   digit [DIGIT_W-1:0] in  : value to show
//   seg   [6:0]         out : segments, bit6=A .. bit0=G; '-' for values above 9
module decod_7seg
    import fechadura_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    // Any value beyond a decimal digit shows a dash, whatever its width.
    always_comb begin
        if (digit > DIGIT_W'(4'd9)) begin
            seg = SEG_DASH;
        end else begin
            seg = digit_to_seg(digit[3:0]);
        end
    end

endmodule

// File: rtl/fechadura_codigo.sv
// fechadura_codigo: parametrised digit-code lock with error lockout and a
// user-programmable code.
//   clk       in  : system clock, rising edge
//   reset     in  : asynchronous, active-high; restores the factory code
//   insere    in  : digit strobe, a digit is taken on its rising edge
//   numero    in  : digit value, sampled with the strobe
//   prog      in  : with a strobe while open, enter code programming
//   aberto    out : lock open (registered)
//   erro      out : at least one wrong digit in this attempt (registered)
//   bloqueado out : lockout active (registered)
//   seg       out : active-low seven-segment display (registered)
module fechadura_codigo
    import fechadura_pkg::*;
#(
    parameter int DIGIT_W     = 4,
    parameter int CODE_LEN    = 6,
    parameter int MAX_ERR     = 2,
    parameter int LOCK_CYCLES = 1000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 24'h590281
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               insere,
    input  logic [DIGIT_W-1:0] numero,
    input  logic               prog,
    output logic               aberto,
    output logic               erro,
    output logic               bloqueado,
    output logic [6:0]         seg
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int BASE_W = $clog2(CODE_W);
    localparam int POS_W  = $clog2(CODE_LEN);
    localparam int ERR_W  = $clog2(MAX_ERR + 1);
    localparam int LOCK_W = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(CODE_LEN - 1);
    localparam logic [ERR_W-1:0]  ERR_LIMIT = ERR_W'(MAX_ERR);
    localparam logic [LOCK_W-1:0] LOCK_LAST = (LOCK_CYCLES > 0) ? LOCK_W'(LOCK_CYCLES - 1) : '0;

    state_t              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CODE_W-1:0]   code_reg_q, code_reg_d;
    logic [CODE_W-1:0]   shadow_q, shadow_d;
    logic                ins_q, ins_d;
    logic                aberto_q, aberto_d;
    logic                erro_q, erro_d;
    logic                bloqueado_q, bloqueado_d;
    logic [6:0]          seg_q, seg_d;

    logic                strobe_s;
    logic                digit_ok_s;
    logic [BASE_W-1:0]   base_s;
    logic [DIGIT_W-1:0]  code_digit_s;
    logic [CODE_W-1:0]   shadow_wr_s;
    logic [ERR_W-1:0]    err_inc_s;
    logic [6:0]          dec_seg_s;

    decod_7seg #(.DIGIT_W(DIGIT_W)) u_decod (
        .digit (numero),
        .seg   (dec_seg_s)
    );

    // Strobe edge detect and digit-slot addressing (first digit sits in the MS slice).
    always_comb begin
        strobe_s     = insere & ~ins_q;
        digit_ok_s   = (numero <= DIGIT_W'(4'd9));
        err_inc_s    = err_cnt_q + ERR_W'(1);
        base_s       = BASE_W'((CODE_LEN - 1 - int'(pos_q)) * DIGIT_W);
        code_digit_s = code_reg_q[base_s +: DIGIT_W];
        shadow_wr_s  = shadow_q;
        shadow_wr_s[base_s +: DIGIT_W] = numero;
    end

    // Lock state machine and its counters.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        err_cnt_d  = err_cnt_q;
        lock_cnt_d = lock_cnt_q;
        code_reg_d = code_reg_q;
        shadow_d   = shadow_q;
        ins_d      = insere;
        case (state_q)
            ST_ENTRADA: begin
                if (strobe_s) begin
                    if (numero == code_digit_s) begin
                        if (pos_q == POS_LAST) begin
                            state_d = ST_ABERTO;
                            pos_d   = '0;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        // A wrong digit keeps pos, so the same digit is retried.
                        err_cnt_d = err_inc_s;
                        if (err_inc_s == ERR_LIMIT) begin
                            state_d    = ST_BLOQUEADO;
                            lock_cnt_d = '0;
                        end else begin
                            state_d = ST_ENTRADA;
                        end
                    end
                end else begin
                    state_d = ST_ENTRADA;
                end
            end
            ST_ABERTO: begin
                if (strobe_s) begin
                    pos_d = '0;
                    if (prog) begin
                        state_d  = ST_PROGRAMA;
                        shadow_d = code_reg_q;
                    end else begin
                        state_d   = ST_ENTRADA;
                        err_cnt_d = '0;
                    end
                end else begin
                    state_d = ST_ABERTO;
                end
            end
            ST_PROGRAMA: begin
                if (strobe_s) begin
                    if (digit_ok_s) begin
                        shadow_d = shadow_wr_s;
                        if (pos_q == POS_LAST) begin
                            // Commit includes the digit being written this cycle.
                            code_reg_d = shadow_wr_s;
                            state_d    = ST_ENTRADA;
                            pos_d      = '0;
                            err_cnt_d  = '0;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        state_d = ST_ABERTO;
                        pos_d   = '0;
                    end
                end else begin
                    state_d = ST_PROGRAMA;
                end
            end
            ST_BLOQUEADO: begin
                // Strobes are ignored here, including one in the expiry cycle.
                if (LOCK_CYCLES > 0) begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_d    = ST_ENTRADA;
                        pos_d      = '0;
                        err_cnt_d  = '0;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                    end
                end else begin
                    state_d = ST_BLOQUEADO;
                end
            end
            default: begin
                state_d = ST_ENTRADA;
                pos_d   = '0;
            end
        endcase
    end

    // Output flags and display follow the next state so they line up with it.
    always_comb begin
        aberto_d    = (state_d == ST_ABERTO);
        erro_d      = (err_cnt_d != '0);
        bloqueado_d = (state_d == ST_BLOQUEADO);
        case (state_d)
            ST_ABERTO:    seg_d = SEG_A;
            ST_BLOQUEADO: seg_d = SEG_F;
            default:      seg_d = dec_seg_s;
        endcase
    end

    // State, counters, code storage and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ENTRADA;
            pos_q       <= '0;
            err_cnt_q   <= '0;
            lock_cnt_q  <= '0;
            code_reg_q  <= CODE;
            shadow_q    <= CODE;
            ins_q       <= 1'b0;
            aberto_q    <= 1'b0;
            erro_q      <= 1'b0;
            bloqueado_q <= 1'b0;
            seg_q       <= SEG_BLANK;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            err_cnt_q   <= err_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            code_reg_q  <= code_reg_d;
            shadow_q    <= shadow_d;
            ins_q       <= ins_d;
            aberto_q    <= aberto_d;
            erro_q      <= erro_d;
            bloqueado_q <= bloqueado_d;
            seg_q       <= seg_d;
        end
    end

    assign aberto    = aberto_q;
    assign erro      = erro_q;
    assign bloqueado = bloqueado_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_fechadura_codigo.sv
// Testbench for fechadura_codigo: directed scenarios plus randomized traffic
// checked against a behavioural model of the lock.
module tb_fechadura_codigo;

    localparam int CL = 6;
    localparam int ME = 2;
    localparam int LC = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       insere = 1'b0;
    logic       prog = 1'b0;
    logic [3:0] numero = 4'd0;
    logic       aberto0, erro0, bloq0;
    logic [6:0] seg0;
    logic       aberto1, erro1, bloq1;
    logic [6:0] seg1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fechadura_codigo #(.LOCK_CYCLES(LC)) dut0 (
        .clk(clk), .reset(reset), .insere(insere), .numero(numero), .prog(prog),
        .aberto(aberto0), .erro(erro0), .bloqueado(bloq0), .seg(seg0)
    );

    fechadura_codigo #(.LOCK_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .insere(insere), .numero(numero), .prog(prog),
        .aberto(aberto1), .erro(erro1), .bloqueado(bloq1), .seg(seg1)
    );

    // ---------------- behavioural model (of dut0) ----------------
    typedef enum {M_ENTRY, M_OPEN, M_PROG, M_LOCK} mode_t;
    mode_t      m_mode;
    int         fact [CL] = '{5, 9, 0, 2, 8, 1};
    int         m_code [CL];
    int         m_shadow [CL];
    int         m_pos, m_errs, m_lock_left;
    bit         m_prev;
    logic [9:0] e_vec;   // {aberto, erro, bloqueado, seg}

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_ENTRY;
        m_code = fact;
        m_shadow = fact;
        m_pos = 0;
        m_errs = 0;
        m_lock_left = 0;
        m_prev = 1'b0;
        e_vec = {3'b000, 7'b1111111};
    endtask

    task automatic model_step(input bit ins, input int num, input bit pr);
        bit st;
        logic [6:0] s;
        st = ins && !m_prev;
        m_prev = ins;
        case (m_mode)
            M_ENTRY: if (st) begin
                if (num == m_code[m_pos]) begin
                    if (m_pos == CL - 1) begin m_mode = M_OPEN; m_pos = 0; end
                    else m_pos++;
                end else begin
                    m_errs++;
                    if (m_errs == ME) begin m_mode = M_LOCK; m_lock_left = LC; end
                end
            end
            M_OPEN: if (st) begin
                m_pos = 0;
                if (pr) begin m_mode = M_PROG; m_shadow = m_code; end
                else begin m_mode = M_ENTRY; m_errs = 0; end
            end
            M_PROG: if (st) begin
                if (num <= 9) begin
                    m_shadow[m_pos] = num;
                    if (m_pos == CL - 1) begin
                        m_code = m_shadow; m_mode = M_ENTRY; m_pos = 0; m_errs = 0;
                    end else m_pos++;
                end else begin
                    m_mode = M_OPEN; m_pos = 0;
                end
            end
            default: begin
                m_lock_left--;
                if (m_lock_left == 0) begin m_mode = M_ENTRY; m_pos = 0; m_errs = 0; end
            end
        endcase
        if (m_mode == M_OPEN) s = 7'b0001000;
        else if (m_mode == M_LOCK) s = 7'b0111000;
        else s = seg_of(num);
        e_vec = {m_mode == M_OPEN, m_errs != 0, m_mode == M_LOCK, s};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit i, input int n, input bit p);
        insere = i;
        numero = 4'(n);
        prog = p;
        @(posedge clk);
        model_step(i, n, p);
        #1;
    endtask

    task automatic strobe_digit(input int n, input bit p);
        tick(1'b1, n, p);
        tick(1'b0, n, p);
        tick(1'b0, n, p);
        tick(1'b0, n, p);
    endtask

    task automatic enter_factory();
        for (int i = 0; i < CL; i++) strobe_digit(fact[i], 1'b0);
    endtask

    task automatic assert_reset();
        insere = 1'b0;
        prog = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_reset();
        assert_reset();
        release_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b000_1111111) begin
            n_errors++;
            $display("FAIL reset_dut0: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b000_1111111);
        end
        n_checks++;
        if ({aberto1, erro1, bloq1, seg1} !== 10'b000_1111111) begin
            n_errors++;
            $display("FAIL reset_dut1: got %b want %b", {aberto1, erro1, bloq1, seg1}, 10'b000_1111111);
        end
    endtask

    task automatic test_unlock();
        do_reset();
        for (int i = 0; i < CL - 1; i++) strobe_digit(fact[i], 1'b0);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b000_0000000) begin
            n_errors++;
            $display("FAIL unlock_5digits: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b000_0000000);
        end
        tick(1'b1, 1, 1'b0);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b100_0001000) begin
            n_errors++;
            $display("FAIL unlock_open: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b100_0001000);
        end
        tick(1'b0, 1, 1'b0);
        strobe_digit(0, 1'b0);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b000_0000001) begin
            n_errors++;
            $display("FAIL unlock_relock: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b000_0000001);
        end
    endtask

    task automatic test_retry();
        do_reset();
        strobe_digit(5, 1'b0);
        strobe_digit(3, 1'b0);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b010_0000110) begin
            n_errors++;
            $display("FAIL retry_err: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b010_0000110);
        end
        for (int i = 1; i < CL; i++) strobe_digit(fact[i], 1'b0);
        n_checks++;
        if ({aberto0, bloq0, seg0} !== 9'b10_0001000) begin
            n_errors++;
            $display("FAIL retry_open: got %b want %b", {aberto0, bloq0, seg0}, 9'b10_0001000);
        end
    endtask

    task automatic test_lockout();
        do_reset();
        strobe_digit(5, 1'b0);
        strobe_digit(3, 1'b0);
        tick(1'b1, 4, 1'b0);   // lockout entered at this edge
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b011_0111000) begin
            n_errors++;
            $display("FAIL lock_enter: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b011_0111000);
        end
        n_checks++;
        if ({aberto1, erro1, bloq1, seg1} !== 10'b011_0111000) begin
            n_errors++;
            $display("FAIL lock0_enter: got %b want %b", {aberto1, erro1, bloq1, seg1}, 10'b011_0111000);
        end
        repeat (3) tick(1'b0, 4, 1'b0);
        enter_factory();                 // 24 more cycles, all ignored
        repeat (22) tick(1'b0, 1, 1'b0); // 49 cycles after entry
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b011_0111000) begin
            n_errors++;
            $display("FAIL lock_hold: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b011_0111000);
        end
        tick(1'b1, 5, 1'b0);             // expiry cycle, strobe ignored
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b000_0100100) begin
            n_errors++;
            $display("FAIL lock_expire: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b000_0100100);
        end
        tick(1'b0, 5, 1'b0);
        enter_factory();
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b100_0001000) begin
            n_errors++;
            $display("FAIL lock_after_open: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b100_0001000);
        end
        repeat (100) tick(1'b0, 0, 1'b0);
        n_checks++;
        if ({aberto1, erro1, bloq1, seg1} !== 10'b011_0111000) begin
            n_errors++;
            $display("FAIL lock0_stays: got %b want %b", {aberto1, erro1, bloq1, seg1}, 10'b011_0111000);
        end
        do_reset();
        n_checks++;
        if ({aberto1, erro1, bloq1, seg1} !== 10'b000_1111111) begin
            n_errors++;
            $display("FAIL lock0_reset: got %b want %b", {aberto1, erro1, bloq1, seg1}, 10'b000_1111111);
        end
    endtask

    task automatic test_program();
        do_reset();
        enter_factory();
        strobe_digit(0, 1'b1);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b000_0000001) begin
            n_errors++;
            $display("FAIL prog_enter: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b000_0000001);
        end
        for (int i = 1; i <= CL; i++) strobe_digit(i, 1'b0);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b000_0100000) begin
            n_errors++;
            $display("FAIL prog_commit: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b000_0100000);
        end
        for (int i = 1; i <= CL; i++) strobe_digit(i, 1'b0);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b100_0001000) begin
            n_errors++;
            $display("FAIL prog_new_open: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b100_0001000);
        end
        strobe_digit(0, 1'b0);
        strobe_digit(5, 1'b0);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b010_0100100) begin
            n_errors++;
            $display("FAIL prog_old_rejected: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b010_0100100);
        end
        do_reset();
        enter_factory();
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b100_0001000) begin
            n_errors++;
            $display("FAIL prog_factory_restored: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b100_0001000);
        end
    endtask

    task automatic test_abort();
        do_reset();
        enter_factory();
        strobe_digit(0, 1'b1);
        strobe_digit(1, 1'b0);
        strobe_digit(2, 1'b0);
        strobe_digit(3, 1'b0);
        strobe_digit(12, 1'b0);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b100_0001000) begin
            n_errors++;
            $display("FAIL abort_open: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b100_0001000);
        end
        strobe_digit(0, 1'b0);
        enter_factory();
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b100_0001000) begin
            n_errors++;
            $display("FAIL abort_old_code: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b100_0001000);
        end
    endtask

    task automatic test_hold();
        do_reset();
        repeat (20) tick(1'b1, 5, 1'b0);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b000_0100100) begin
            n_errors++;
            $display("FAIL hold_single: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b000_0100100);
        end
        repeat (3) tick(1'b0, 5, 1'b0);
        for (int i = 1; i < CL; i++) strobe_digit(fact[i], 1'b0);
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b100_0001000) begin
            n_errors++;
            $display("FAIL hold_open: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b100_0001000);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enter_factory();
        strobe_digit(0, 1'b1);
        strobe_digit(1, 1'b0);
        strobe_digit(2, 1'b0);
        insere = 1'b1;
        numero = 4'd3;
        assert_reset();
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b000_1111111) begin
            n_errors++;
            $display("FAIL rst_mid_prog: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b000_1111111);
        end
        release_reset();
        strobe_digit(5, 1'b0);
        strobe_digit(3, 1'b0);
        strobe_digit(4, 1'b0);
        assert_reset();
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b000_1111111) begin
            n_errors++;
            $display("FAIL rst_mid_lock: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b000_1111111);
        end
        release_reset();
        enter_factory();
        n_checks++;
        if ({aberto0, erro0, bloq0, seg0} !== 10'b100_0001000) begin
            n_errors++;
            $display("FAIL rst_mid_factory: got %b want %b", {aberto0, erro0, bloq0, seg0}, 10'b100_0001000);
        end
    endtask

    task automatic test_random();
        int n;
        bit i, p;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 1) == 1);
            if (m_mode == M_ENTRY && $urandom_range(0, 9) < 8) n = m_code[m_pos];
            else if (m_mode == M_PROG) n = $urandom_range(0, 10);
            else n = $urandom_range(0, 15);
            tick(i, n, p);
            n_checks++;
            if ({aberto0, erro0, bloq0, seg0} !== e_vec) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got %b want %b", c, {aberto0, erro0, bloq0, seg0}, e_vec);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_unlock();
        test_retry();
        test_lockout();
        test_program();
        test_abort();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
